// File: rtl/coms_bus_scheduler.sv
// coms_bus_scheduler: sequences the half-duplex motor UART bus.
// Chooses the next frame (control mode > setpoint > status poll), drives the
// frame transmitter through a start/done handshake and holds the bus for a
// response window after every status request.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   update_frequency_Hz   per-motor status poll rate, 0 disables polling
//   cm_update_req         per-motor pulse: control-mode frame wanted
//   sp_update_req         per-motor pulse: setpoint frame wanted
//   frame_busy            transmitter active
//   frame_done            pulse: last byte of current frame sent
//   status_ok             pulse: CRC-valid status frame received
//   status_motor          motor id carried by that status frame
//   frame_start           pulse: build and send frame_type/frame_motor
//   frame_type            0 = status request, 1 = setpoint, 2 = control mode
//   frame_motor           target motor id
//   listening             high during the response window
//   timeout               pulse: window expired without a matching status
//   cm_pending            outstanding control-mode requests
//   sp_pending            outstanding setpoint requests
module coms_bus_scheduler #(
  parameter int unsigned NUMBER_OF_MOTORS      = 8,
  parameter int unsigned CLK_FREQ_HZ           = 50_000_000,
  parameter int unsigned BAUDRATE              = 2_000_000,
  parameter int unsigned RESPONSE_WINDOW_BYTES = 26,
  parameter int unsigned SLOT_BITS             = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 update_frequency_Hz,
  input  logic [NUMBER_OF_MOTORS-1:0] cm_update_req,
  input  logic [NUMBER_OF_MOTORS-1:0] sp_update_req,
  input  logic                        frame_busy,
  input  logic                        frame_done,
  input  logic                        status_ok,
  input  logic [7:0]                  status_motor,
  output logic                        frame_start,
  output logic [1:0]                  frame_type,
  output logic [7:0]                  frame_motor,
  output logic                        listening,
  output logic                        timeout,
  output logic [NUMBER_OF_MOTORS-1:0] cm_pending,
  output logic [NUMBER_OF_MOTORS-1:0] sp_pending
);

  localparam int unsigned N       = NUMBER_OF_MOTORS;
  localparam int unsigned MOTOR_W = 8;
  localparam int unsigned TYPE_W  = 2;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned DIV_W   = 64;

  localparam logic [TYPE_W-1:0] TYPE_STATUS = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] TYPE_SP     = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] TYPE_CM     = TYPE_W'(2);

  // Response window length in clock cycles, counted down to 0 inclusive.
  localparam logic [CNT_W-1:0] WINDOW_LOAD =
    CNT_W'((CLK_FREQ_HZ / BAUDRATE) * RESPONSE_WINDOW_BYTES * SLOT_BITS - 1);

  localparam logic [MOTOR_W-1:0] LAST_MOTOR = MOTOR_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_TX = 2'd1,
    LISTEN  = 2'd2
  } state_t;

  state_t             state;
  logic [MOTOR_W-1:0] rr;
  logic [MOTOR_W-1:0] poll_motor;
  logic [CNT_W-1:0]   poll_cnt;
  logic [CNT_W-1:0]   window_cnt;

  logic               cm_found;
  logic               sp_found;
  logic [MOTOR_W-1:0] cm_sel;
  logic [MOTOR_W-1:0] sp_sel;
  logic               poll_due;
  logic               issue_cm;
  logic               issue_sp;
  logic               issue_poll;
  logic [N-1:0]       cm_clr;
  logic [N-1:0]       sp_clr;
  logic [CNT_W-1:0]   poll_load;
  logic [DIV_W-1:0]   poll_div;
  logic               status_match;

  // First set bit of vec scanning cyclically from start; returns {found, index}.
  // Split into "at or above start" and "anywhere" so no variable bit select is needed.
  function automatic logic [MOTOR_W:0] pick_rr(input logic [N-1:0]       vec,
                                               input logic [MOTOR_W-1:0] start);
    logic               hi_found;
    logic               lo_found;
    logic [MOTOR_W-1:0] hi_idx;
    logic [MOTOR_W-1:0] lo_idx;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = 0; j < N; j++) begin
      if (vec[j]) begin
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = MOTOR_W'(j);
        end
        if (!hi_found && (MOTOR_W'(j) >= start)) begin
          hi_found = 1'b1;
          hi_idx   = MOTOR_W'(j);
        end
      end
    end
    if (hi_found) begin
      return {1'b1, hi_idx};
    end
    return {lo_found, lo_idx};
  endfunction

  // Motor id + 1, wrapping the last motor back to 0.
  function automatic logic [MOTOR_W-1:0] next_motor(input logic [MOTOR_W-1:0] m);
    return (m == LAST_MOTOR) ? '0 : m + MOTOR_W'(1);
  endfunction

  // Candidate selection for the IDLE state.
  always_comb begin
    {cm_found, cm_sel} = pick_rr(cm_pending, rr);
    {sp_found, sp_sel} = pick_rr(sp_pending, rr);
  end

  // Poll interval reload; the zero guard only matters while polling is off.
  always_comb begin
    poll_div  = '0;
    poll_load = '0;
    if (update_frequency_Hz != '0) begin
      poll_div  = DIV_W'(CLK_FREQ_HZ) / (DIV_W'(update_frequency_Hz) * DIV_W'(N));
      poll_load = CNT_W'(poll_div);
    end
  end

  // Issue decisions in strict priority order.
  always_comb begin
    poll_due   = (poll_cnt == '0) && (update_frequency_Hz != '0);
    issue_cm   = 1'b0;
    issue_sp   = 1'b0;
    issue_poll = 1'b0;
    if ((state == IDLE) && !frame_busy) begin
      if (cm_found) begin
        issue_cm = 1'b1;
      end else if (sp_found) begin
        issue_sp = 1'b1;
      end else if (poll_due) begin
        issue_poll = 1'b1;
      end
    end
  end

  // Pending-flag clear masks; a control-mode frame also satisfies the setpoint.
  always_comb begin
    cm_clr = '0;
    sp_clr = '0;
    for (int j = 0; j < N; j++) begin
      cm_clr[j] = issue_cm && (cm_sel == MOTOR_W'(j));
      sp_clr[j] = (issue_cm && (cm_sel == MOTOR_W'(j))) ||
                  (issue_sp && (sp_sel == MOTOR_W'(j)));
    end
  end

  assign status_match = status_ok && (status_motor == frame_motor);

  // Scheduler state, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr          <= '0;
      poll_motor  <= '0;
      poll_cnt    <= '0;
      window_cnt  <= '0;
      frame_start <= 1'b0;
      frame_type  <= '0;
      frame_motor <= '0;
      listening   <= 1'b0;
      timeout     <= 1'b0;
      cm_pending  <= '0;
      sp_pending  <= '0;
    end else begin
      frame_start <= 1'b0;
      timeout     <= 1'b0;

      // New requests win over a same-cycle clear.
      cm_pending <= (cm_pending & ~cm_clr) | cm_update_req;
      sp_pending <= (sp_pending & ~sp_clr) | sp_update_req;

      if (issue_poll) begin
        poll_cnt <= poll_load;
      end else if (poll_cnt != '0) begin
        poll_cnt <= poll_cnt - CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (issue_cm) begin
            frame_type  <= TYPE_CM;
            frame_motor <= cm_sel;
            rr          <= next_motor(cm_sel);
            frame_start <= 1'b1;
            state       <= WAIT_TX;
          end else if (issue_sp) begin
            frame_type  <= TYPE_SP;
            frame_motor <= sp_sel;
            rr          <= next_motor(sp_sel);
            frame_start <= 1'b1;
            state       <= WAIT_TX;
          end else if (issue_poll) begin
            frame_type  <= TYPE_STATUS;
            frame_motor <= poll_motor;
            poll_motor  <= next_motor(poll_motor);
            frame_start <= 1'b1;
            state       <= WAIT_TX;
          end
        end

        WAIT_TX: begin
          if (frame_done) begin
            if (frame_type == TYPE_STATUS) begin
              window_cnt <= WINDOW_LOAD;
              listening  <= 1'b1;
              state      <= LISTEN;
            end else begin
              state <= IDLE;
            end
          end
        end

        LISTEN: begin
          // A matching reply beats an expiring window in the same cycle.
          if (status_match) begin
            listening <= 1'b0;
            state     <= IDLE;
          end else if (window_cnt == '0) begin
            listening <= 1'b0;
            timeout   <= 1'b1;
            state     <= IDLE;
          end else begin
            window_cnt <= window_cnt - CNT_W'(1);
          end
        end

        default: begin
          listening <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coms_bus_scheduler.sv
// tb_coms_bus_scheduler: directed bench for coms_bus_scheduler with N=4,
// 1 kHz clock, 100 baud, 2-byte window of 12-bit slots (239-cycle window load).
module tb_coms_bus_scheduler;

  localparam int unsigned N = 4;

  logic         clk;
  logic         reset;
  logic [31:0]  update_frequency_Hz;
  logic [N-1:0] cm_update_req;
  logic [N-1:0] sp_update_req;
  logic         frame_busy;
  logic         frame_done;
  logic         status_ok;
  logic [7:0]   status_motor;
  logic         frame_start;
  logic [1:0]   frame_type;
  logic [7:0]   frame_motor;
  logic         listening;
  logic         timeout;
  logic [N-1:0] cm_pending;
  logic [N-1:0] sp_pending;

  coms_bus_scheduler #(
    .NUMBER_OF_MOTORS     (N),
    .CLK_FREQ_HZ          (1000),
    .BAUDRATE             (100),
    .RESPONSE_WINDOW_BYTES(2),
    .SLOT_BITS            (12)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .update_frequency_Hz(update_frequency_Hz),
    .cm_update_req      (cm_update_req),
    .sp_update_req      (sp_update_req),
    .frame_busy         (frame_busy),
    .frame_done         (frame_done),
    .status_ok          (status_ok),
    .status_motor       (status_motor),
    .frame_start        (frame_start),
    .frame_type         (frame_type),
    .frame_motor        (frame_motor),
    .listening          (listening),
    .timeout            (timeout),
    .cm_pending         (cm_pending),
    .sp_pending         (sp_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0] t;
    logic [7:0] m;
    int         c;
  } start_t;

  start_t st_q[$];
  int     lis_q[$];
  int     lis_run = 0;
  int     to_cnt  = 0;
  int     tx_cnt  = 0;
  int     total   = 0;
  int     bad     = 0;

  // Transmitter model: frame_done pulses 5 cycles after frame_start.
  always @(negedge clk) begin
    frame_done = 1'b0;
    if (reset) begin
      tx_cnt     = 0;
      frame_busy = 1'b0;
    end else if (frame_start) begin
      tx_cnt     = 5;
      frame_busy = 1'b1;
    end else if (tx_cnt != 0) begin
      tx_cnt = tx_cnt - 1;
      if (tx_cnt == 0) begin
        frame_done = 1'b1;
        frame_busy = 1'b0;
      end
    end
  end

  // Monitor: log frame starts, timeout pulses and listening run lengths.
  always @(negedge clk) begin
    if (reset) begin
      lis_run = 0;
    end else begin
      if (frame_start) st_q.push_back('{t: frame_type, m: frame_motor, c: cyc});
      if (timeout) to_cnt = to_cnt + 1;
      if (listening) begin
        lis_run = lis_run + 1;
      end else if (lis_run != 0) begin
        lis_q.push_back(lis_run);
        lis_run = 0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return 32'({frame_start, frame_type, frame_motor, listening, timeout, cm_pending, sp_pending});
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    cm_update_req = '0;
    sp_update_req = '0;
    status_ok     = 1'b0;
    status_motor  = '0;
    step(3);
    st_q.delete();
    lis_q.delete();
    to_cnt = 0;
    reset  = 1'b0;
  endtask

  task automatic wait_start(input int budget, output logic [1:0] t, output logic [7:0] m,
                            output int c);
    int     n;
    start_t e;
    n = 0;
    while (st_q.size() == 0 && n < budget) begin
      step(1);
      n++;
    end
    if (st_q.size() == 0) begin
      check_val("start_wait", 32'd0, 32'd1);
      t = '1;
      m = '1;
      c = -1000;
    end else begin
      e = st_q.pop_front();
      t = e.t;
      m = e.m;
      c = e.c;
    end
  endtask

  task automatic wait_listen(input int budget);
    int n;
    n = 0;
    while (!listening && n < budget) begin
      step(1);
      n++;
    end
    check_val("listen_wait", 32'(listening), 32'd1);
  endtask

  logic [1:0] t;
  logic [7:0] m;
  int         c;
  int         c_prev;
  int         to_before;
  int         n;

  initial begin
    reset               = 1'b1;
    update_frequency_Hz = 32'd10;
    cm_update_req       = '0;
    sp_update_req       = '0;
    status_ok           = 1'b0;
    status_motor        = '0;
    frame_busy          = 1'b0;
    frame_done          = 1'b0;

    step(1);
    check_val("reset_outs", outs_vec(), 32'd0);

    // Free-running polls with no replies: 247-cycle period, 240-cycle windows.
    do_reset();
    c_prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_start(400, t, m, c);
      check_val("poll_type", 32'(t), 32'd0);
      check_val("poll_motor", 32'(m), 32'(i % 4));
      if (i > 0) check_val("poll_gap", 32'(c - c_prev), 32'd247);
      c_prev = c;
    end
    n = 0;
    while (to_cnt < 5 && n < 400) begin
      step(1);
      n++;
    end
    check_val("timeouts", 32'(to_cnt), 32'd5);
    check_val("windows", 32'(lis_q.size()), 32'd5);
    while (lis_q.size() != 0) check_val("window_len", 32'(lis_q.pop_front()), 32'd240);

    // Matching reply in window cycle 50 for motor 1.
    wait_start(20, t, m, c);
    check_val("poll6_motor", 32'(m), 32'd1);
    wait_listen(20);
    step(49);
    status_ok    = 1'b1;
    status_motor = 8'd1;
    to_before    = to_cnt;
    step(1);
    status_ok = 1'b0;
    check_val("match_drop", 32'(listening), 32'd0);
    step(5);
    check_val("match_no_to", 32'(to_cnt), 32'(to_before));
    check_val("match_len", (lis_q.size() != 0) ? 32'(lis_q.pop_front()) : 32'd0, 32'd50);

    // Mismatched reply is ignored and the window runs to timeout.
    wait_start(20, t, m, c);
    check_val("poll7_motor", 32'(m), 32'd2);
    wait_listen(20);
    step(10);
    status_ok    = 1'b1;
    status_motor = 8'd3;
    to_before    = to_cnt;
    step(1);
    status_ok = 1'b0;
    check_val("mismatch_ignored", 32'(listening), 32'd1);
    n = 0;
    while (to_cnt == to_before && n < 300) begin
      step(1);
      n++;
    end
    check_val("mismatch_to", 32'(to_cnt), 32'(to_before + 1));
    check_val("mismatch_len", (lis_q.size() != 0) ? 32'(lis_q.pop_front()) : 32'd0, 32'd240);

    // Priority and round robin with polling disabled, then polling resumes.
    update_frequency_Hz = 32'd0;
    do_reset();
    step(2);
    check_val("idle_no_start", 32'(st_q.size()), 32'd0);
    cm_update_req = 4'b0101;
    sp_update_req = 4'b1100;
    step(1);
    cm_update_req = '0;
    sp_update_req = '0;
    check_val("pend_cm_set", 32'(cm_pending), 32'b0101);
    check_val("pend_sp_set", 32'(sp_pending), 32'b1100);
    wait_start(10, t, m, c);
    check_val("first_type", 32'(t), 32'd2);
    check_val("first_motor", 32'(m), 32'd0);
    c_prev = c;
    wait_start(20, t, m, c);
    check_val("second_type", 32'(t), 32'd2);
    check_val("second_motor", 32'(m), 32'd2);
    check_val("second_gap", 32'(c - c_prev), 32'd7);
    check_val("cm_clears_sp", 32'(sp_pending), 32'b1000);
    check_val("cm_all_clear", 32'(cm_pending), 32'd0);
    c_prev = c;
    wait_start(20, t, m, c);
    check_val("third_type", 32'(t), 32'd1);
    check_val("third_motor", 32'(m), 32'd3);
    check_val("third_gap", 32'(c - c_prev), 32'd7);
    check_val("sp_all_clear", 32'(sp_pending), 32'd0);
    step(300);
    check_val("no_poll_freq0", 32'(st_q.size()), 32'd0);
    update_frequency_Hz = 32'd10;
    wait_start(10, t, m, c);
    check_val("resume_type", 32'(t), 32'd0);
    check_val("resume_motor", 32'(m), 32'd0);

    // Request in the issuing cycle re-arms the flag: two setpoint frames to m1.
    update_frequency_Hz = 32'd0;
    do_reset();
    sp_update_req = 4'b0010;
    step(2);
    sp_update_req = '0;
    wait_start(5, t, m, c);
    check_val("sp1_type", 32'(t), 32'd1);
    check_val("sp1_motor", 32'(m), 32'd1);
    check_val("set_wins", 32'(sp_pending), 32'b0010);
    c_prev = c;
    wait_start(20, t, m, c);
    check_val("sp2_type", 32'(t), 32'd1);
    check_val("sp2_motor", 32'(m), 32'd1);
    check_val("sp2_gap", 32'(c - c_prev), 32'd7);
    check_val("sp2_clear", 32'(sp_pending), 32'd0);

    // Reset while a frame is starting, then while listening.
    do_reset();
    cm_update_req = 4'b0100;
    sp_update_req = 4'b1000;
    step(1);
    cm_update_req = '0;
    sp_update_req = '0;
    wait_start(5, t, m, c);
    check_val("pre_rst_start", 32'(frame_start), 32'd1);
    check_val("pre_rst_motor", 32'(frame_motor), 32'd2);
    check_val("pre_rst_sp", 32'(sp_pending), 32'b1000);
    reset = 1'b1;
    #1;
    check_val("reset_wait_tx", outs_vec(), 32'd0);
    update_frequency_Hz = 32'd10;
    do_reset();
    wait_start(5, t, m, c);
    check_val("post_rst1_type", 32'(t), 32'd0);
    check_val("post_rst1_motor", 32'(m), 32'd0);
    wait_listen(20);
    step(20);
    reset = 1'b1;
    #1;
    check_val("reset_listen", outs_vec(), 32'd0);
    do_reset();
    wait_start(5, t, m, c);
    check_val("post_rst2_type", 32'(t), 32'd0);
    check_val("post_rst2_motor", 32'(m), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
